// File: rtl/tile_feat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_feat_pkg
// Description : Shared widths and the tile result record for the tile feature
//               extractor.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_feat_pkg;

    localparam int YPIX_W = 8;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;
    localparam int TILE_W = 4;
    localparam int TILE_H = 4;

    localparam int G_W    = YPIX_W + 1;
    localparam int SUMY_W = YPIX_W + $clog2(TILE_W * TILE_H);
    localparam int SUMG_W = G_W + $clog2(TILE_W * TILE_H);
    localparam int TX_W   = $clog2(IMG_W / TILE_W);
    localparam int TY_W   = $clog2(IMG_H / TILE_H);

    typedef struct packed {
        logic [TX_W-1:0]   tile_x;
        logic [TY_W-1:0]   tile_y;
        logic [SUMY_W-1:0] sum_y;
        logic [SUMG_W-1:0] sum_g;
        logic [G_W-1:0]    max_g;
    } tile_feat_t;

endpackage
`default_nettype wire

// File: rtl/grad_abs_sum.sv
`default_nettype none
// ============================================================================
// Module      : grad_abs_sum
// Description : Combinational |dx| + |dy| luma gradient with border masking.
// Revision    : 1.0 - initial release
// ============================================================================
module grad_abs_sum #(
    parameter int YPIX_W = tile_feat_pkg::YPIX_W
) (
    input  logic [YPIX_W-1:0] y_cur_i,
    input  logic [YPIX_W-1:0] y_left_i,
    input  logic [YPIX_W-1:0] y_up_i,
    input  logic              first_col_i,
    input  logic              first_row_i,
    output logic [YPIX_W:0]   g_o
);

    logic [YPIX_W-1:0] w_gx;
    logic [YPIX_W-1:0] w_gy;

    // Masks hide the wrap-around left pixel and the previous frame's last row.
    always_comb begin
        w_gx = '0;
        w_gy = '0;
        if (!first_col_i) begin
            w_gx = (y_cur_i >= y_left_i) ? (y_cur_i - y_left_i) : (y_left_i - y_cur_i);
        end
        if (!first_row_i) begin
            w_gy = (y_cur_i >= y_up_i) ? (y_cur_i - y_up_i) : (y_up_i - y_cur_i);
        end
        g_o = {1'b0, w_gx} + {1'b0, w_gy};
    end

endmodule
`default_nettype wire

// File: rtl/tile_grad_accum.sv
`default_nettype none
// ============================================================================
// Module      : tile_grad_accum
// Description : Reduces a raster pixel-neighbourhood stream into per-tile luma
//               sum, gradient sum and gradient maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_grad_accum #(
    parameter int YPIX_W  = tile_feat_pkg::YPIX_W,
    parameter int IMG_W   = tile_feat_pkg::IMG_W,
    parameter int IMG_H   = tile_feat_pkg::IMG_H,
    parameter int TILE_W  = tile_feat_pkg::TILE_W,
    parameter int TILE_H  = tile_feat_pkg::TILE_H,
    localparam int G_W    = YPIX_W + 1,
    localparam int SUMY_W = YPIX_W + $clog2(TILE_W * TILE_H),
    localparam int SUMG_W = G_W + $clog2(TILE_W * TILE_H),
    localparam int TX_W   = $clog2(IMG_W / TILE_W),
    localparam int TY_W   = $clog2(IMG_H / TILE_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              v2_valid,
    output logic              v2_ready,
    input  logic [YPIX_W-1:0] y_cur,
    input  logic [YPIX_W-1:0] y_left,
    input  logic [YPIX_W-1:0] y_up,
    output logic              t_valid,
    input  logic              t_ready,
    output logic [TX_W-1:0]   tile_x,
    output logic [TY_W-1:0]   tile_y,
    output logic [SUMY_W-1:0] sum_y,
    output logic [SUMG_W-1:0] sum_g,
    output logic [G_W-1:0]    max_g
);

    localparam int NTX    = IMG_W / TILE_W;
    localparam int PX_W   = $clog2(IMG_W);
    localparam int PY_W   = $clog2(IMG_H);
    localparam int LOG_TW = $clog2(TILE_W);
    localparam int LOG_TH = $clog2(TILE_H);
    localparam logic [PX_W-1:0] TW_MASK = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0] TH_MASK = PY_W'(TILE_H - 1);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(IMG_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(IMG_H - 1);

    logic [PX_W-1:0]   px_q, px_d;
    logic [PY_W-1:0]   py_q, py_d;
    logic [SUMY_W-1:0] acc_sy_q [NTX];
    logic [SUMG_W-1:0] acc_sg_q [NTX];
    logic [G_W-1:0]    acc_mg_q [NTX];
    logic [SUMY_W-1:0] sy_d;
    logic [SUMG_W-1:0] sg_d;
    logic [G_W-1:0]    mg_d;

    logic              t_valid_q;
    logic [TX_W-1:0]   tile_x_q;
    logic [TY_W-1:0]   tile_y_q;
    logic [SUMY_W-1:0] sum_y_q;
    logic [SUMG_W-1:0] sum_g_q;
    logic [G_W-1:0]    max_g_q;

    logic              w_accept;
    logic              w_tile_first;
    logic              w_tile_last;
    logic [TX_W-1:0]   w_tx;
    logic [TY_W-1:0]   w_ty;
    logic [G_W-1:0]    w_g;

    // Input stalls whenever a result is held, even if the next beat would not complete a tile.
    assign v2_ready     = en && !clr && (!t_valid_q || t_ready);
    assign w_accept     = v2_valid && v2_ready;
    assign w_tx         = TX_W'(px_q >> LOG_TW);
    assign w_ty         = TY_W'(py_q >> LOG_TH);
    assign w_tile_first = ((px_q & TW_MASK) == '0) && ((py_q & TH_MASK) == '0);
    assign w_tile_last  = ((px_q & TW_MASK) == TW_MASK) && ((py_q & TH_MASK) == TH_MASK);

    grad_abs_sum #(
        .YPIX_W      (YPIX_W)
    ) u_grad (
        .y_cur_i     (y_cur),
        .y_left_i    (y_left),
        .y_up_i      (y_up),
        .first_col_i (px_q == '0),
        .first_row_i (py_q == '0),
        .g_o         (w_g)
    );

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (w_accept) begin
            if (px_q == PX_LAST) begin
                px_d = '0;
                py_d = (py_q == PY_LAST) ? '0 : py_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
    end

    always_comb begin
        sy_d = SUMY_W'(y_cur);
        sg_d = SUMG_W'(w_g);
        mg_d = w_g;
        if (!w_tile_first) begin
            sy_d = acc_sy_q[w_tx] + SUMY_W'(y_cur);
            sg_d = acc_sg_q[w_tx] + SUMG_W'(w_g);
            if (acc_mg_q[w_tx] > w_g) begin
                mg_d = acc_mg_q[w_tx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (en && clr)) begin
            px_q      <= '0;
            py_q      <= '0;
            t_valid_q <= 1'b0;
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            sum_y_q   <= '0;
            sum_g_q   <= '0;
            max_g_q   <= '0;
            for (int i = 0; i < NTX; i++) begin
                acc_sy_q[i] <= '0;
                acc_sg_q[i] <= '0;
                acc_mg_q[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                px_q           <= px_d;
                py_q           <= py_d;
                acc_sy_q[w_tx] <= sy_d;
                acc_sg_q[w_tx] <= sg_d;
                acc_mg_q[w_tx] <= mg_d;
            end
            // A completion on the consuming edge replaces the result and keeps t_valid high.
            if (w_accept && w_tile_last) begin
                t_valid_q <= 1'b1;
                tile_x_q  <= w_tx;
                tile_y_q  <= w_ty;
                sum_y_q   <= sy_d;
                sum_g_q   <= sg_d;
                max_g_q   <= mg_d;
            end else if (en && t_ready) begin
                t_valid_q <= 1'b0;
            end
        end
    end

    assign t_valid = t_valid_q;
    assign tile_x  = tile_x_q;
    assign tile_y  = tile_y_q;
    assign sum_y   = sum_y_q;
    assign sum_g   = sum_g_q;
    assign max_g   = max_g_q;

endmodule
`default_nettype wire
